// File: rtl/cache_evict_pkg.sv
// rtl/cache_evict_pkg.sv - shared types and geometry helpers for the eviction buffer
package cache_evict_pkg;

  localparam int LINELEN_DEF = 512;
  localparam int BEATLEN_DEF = 64;

  typedef enum logic {IDLE, BURST} drainState_e;

  function automatic int beatCount(input int lineLen, input int beatLen);
    return lineLen / beatLen;
  endfunction

  function automatic int offsetBits(input int lineLen);
    return $clog2(lineLen / 8);
  endfunction

  // Start position of a beat given its stride (bits for data slices, bytes for addresses).
  function automatic int beatIndex(input int beat, input int stride);
    return beat * stride;
  endfunction

  localparam int BEATS     = beatCount(LINELEN_DEF, BEATLEN_DEF);
  localparam int OFFSETLEN = offsetBits(LINELEN_DEF);

endpackage

// File: rtl/cache_evict_entry_cam.sv
// rtl/cache_evict_entry_cam.sv - per-entry line tags with valid bits and parallel lookup compare
module cache_evict_entry_cam #(
  parameter int DEPTH  = 2,
  parameter int TAGLEN = 50
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrIdx,
  input  logic [TAGLEN-1:0]        wrTag,
  input  logic                     clrEn,
  input  logic [$clog2(DEPTH)-1:0] clrIdx,
  input  logic [$clog2(DEPTH)-1:0] rdIdx,
  output logic [TAGLEN-1:0]        rdTag,
  input  logic [TAGLEN-1:0]        lookupTag,
  output logic                     lookupHit
);

  logic [TAGLEN-1:0] tagQ [DEPTH];
  logic [DEPTH-1:0]  validQ;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      validQ <= '0;
    end else begin
      if (clrEn) validQ[clrIdx] <= 1'b0;
      if (wrEn)  validQ[wrIdx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) tagQ[wrIdx] <= wrTag;
  end

  // A tag written this cycle is not valid until the edge, so it cannot hit yet.
  always_comb begin
    lookupHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (validQ[i] && (tagQ[i] == lookupTag)) lookupHit = 1'b1;
    end
  end

  assign rdTag = tagQ[rdIdx];

endmodule

// File: rtl/cache_evict_buffer.sv
// rtl/cache_evict_buffer.sv - dirty-victim FIFO streaming each line to the bus as a beat burst
module cache_evict_buffer
  import cache_evict_pkg::*;
#(
  parameter int NUMWAYS = 4,
  parameter int LINELEN = LINELEN_DEF,
  parameter int BEATLEN = BEATLEN_DEF,
  parameter int PA_BITS = 56,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               EvictValid,
  output logic               EvictReady,
  input  logic [PA_BITS-1:0] EvictAdr,
  input  logic [LINELEN-1:0] EvictLine,
  input  logic [NUMWAYS-1:0] EvictWay,
  output logic               BusValid,
  input  logic               BusReady,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [BEATLEN-1:0] BusData,
  output logic               BusLast,
  output logic [NUMWAYS-1:0] BusWay,
  input  logic [PA_BITS-1:0] LookupAdr,
  output logic               LookupHit,
  output logic               Empty
);

  localparam int NumBeats  = beatCount(LINELEN, BEATLEN);
  localparam int OffsetLen = offsetBits(LINELEN);
  localparam int TagLen    = PA_BITS - OffsetLen;
  localparam int PtrW      = $clog2(DEPTH);
  localparam int BeatW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int BeatBytes = BEATLEN / 8;

  logic [PtrW:0]        wrPtr, rdPtr, count;
  logic [PtrW-1:0]      wrIdx, headIdx;
  logic [BeatW-1:0]     beat;
  drainState_e          state;
  logic                 busValidQ;
  logic                 full, empty, enq, deq, lastBeat;
  logic [TagLen-1:0]    headTag;
  logic [BEATLEN-1:0]   dataMem [DEPTH][NumBeats];
  logic [NUMWAYS-1:0]   wayMem  [DEPTH];
  logic                 unusedAdrBits;

  assign wrIdx    = wrPtr[PtrW-1:0];
  assign headIdx  = rdPtr[PtrW-1:0];
  assign count    = wrPtr - rdPtr;
  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[PtrW] != rdPtr[PtrW]) && (wrIdx == headIdx);
  assign enq      = EvictValid & ~full;
  assign lastBeat = (beat == BeatW'(NumBeats - 1));
  assign deq      = busValidQ & BusReady & lastBeat;

  assign EvictReady = ~full;
  assign Empty      = empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (enq) wrPtr <= wrPtr + 1'b1;
      if (deq) rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < NumBeats; i++) begin
        dataMem[wrIdx][i] <= EvictLine[beatIndex(i, BEATLEN) +: BEATLEN];
      end
      wayMem[wrIdx] <= EvictWay;
    end
  end

  // Staying in BURST on the last beat gives back-to-back bursts; a same-cycle enqueue counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busValidQ <= 1'b0;
      beat      <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (!empty) begin
            state     <= BURST;
            busValidQ <= 1'b1;
          end
        end
        BURST: begin
          if (BusReady) begin
            if (lastBeat) begin
              beat <= '0;
              if (!((count > (PtrW+1)'(1)) || enq)) begin
                state     <= IDLE;
                busValidQ <= 1'b0;
              end
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busValidQ <= 1'b0;
          beat      <= '0;
        end
      endcase
    end
  end

  cache_evict_entry_cam #(
    .DEPTH  (DEPTH),
    .TAGLEN (TagLen)
  ) u_cam (
    .clk       (clk),
    .reset_n   (reset_n),
    .wrEn      (enq),
    .wrIdx     (wrIdx),
    .wrTag     (EvictAdr[PA_BITS-1:OffsetLen]),
    .clrEn     (deq),
    .clrIdx    (headIdx),
    .rdIdx     (headIdx),
    .rdTag     (headTag),
    .lookupTag (LookupAdr[PA_BITS-1:OffsetLen]),
    .lookupHit (LookupHit)
  );

  assign BusValid = busValidQ;
  assign BusLast  = busValidQ & lastBeat;
  assign BusData  = dataMem[headIdx][beat];
  assign BusWay   = wayMem[headIdx];
  assign BusAdr   = {headTag, {OffsetLen{1'b0}}} + PA_BITS'(beatIndex(int'(beat), BeatBytes));

  assign unusedAdrBits = ^{EvictAdr[OffsetLen-1:0], LookupAdr[OffsetLen-1:0]};

endmodule

// File: tb/tb_cache_evict_buffer.sv
// tb/tb_cache_evict_buffer.sv - self-checking bench with beat scoreboard and lookup vector table
module tb_cache_evict_buffer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         EvictValid;
  logic         EvictReady;
  logic [55:0]  EvictAdr;
  logic [511:0] EvictLine;
  logic [3:0]   EvictWay;
  logic         BusValid;
  logic         BusReady;
  logic [55:0]  BusAdr;
  logic [63:0]  BusData;
  logic         BusLast;
  logic [3:0]   BusWay;
  logic [55:0]  LookupAdr;
  logic         LookupHit;
  logic         Empty;

  always #5 clk = ~clk;

  cache_evict_buffer #(
    .NUMWAYS (4), .LINELEN (512), .BEATLEN (64), .PA_BITS (56), .DEPTH (2)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .EvictValid (EvictValid), .EvictReady (EvictReady), .EvictAdr (EvictAdr),
    .EvictLine (EvictLine), .EvictWay (EvictWay),
    .BusValid (BusValid), .BusReady (BusReady), .BusAdr (BusAdr), .BusData (BusData),
    .BusLast (BusLast), .BusWay (BusWay),
    .LookupAdr (LookupAdr), .LookupHit (LookupHit), .Empty (Empty)
  );

  typedef struct {
    logic [55:0] adr;
    logic [63:0] data;
    logic        last;
    logic [3:0]  way;
  } beat_t;

  typedef struct {
    logic [55:0] evAdr;
    logic [55:0] lkAdr;
    logic        expHit;
  } lkVec_t;

  beat_t expQ[$];
  int    errors = 0;
  int    checks = 0;
  int    beatsSeen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mkLine(input logic [7:0] seed);
    logic [511:0] l;
    for (int i = 0; i < 64; i++) l[8*i +: 8] = seed + 8'(i);
    return l;
  endfunction

  task automatic pushBeats(input logic [55:0] adr, input logic [7:0] seed, input logic [3:0] way);
    beat_t e;
    for (int b = 0; b < 8; b++) begin
      e.adr = (adr & ~56'h3F) + 56'(8 * b);
      for (int k = 0; k < 8; k++) e.data[8*k +: 8] = seed + 8'(8 * b + k);
      e.last = (b == 7);
      e.way  = way;
      expQ.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that performs the handshake.
  task automatic enqueue(input logic [55:0] adr, input logic [7:0] seed, input logic [3:0] way);
    int t = 0;
    EvictValid = 1'b1; EvictAdr = adr; EvictLine = mkLine(seed); EvictWay = way;
    @(negedge clk); #1;
    while (!EvictReady && t < 200) begin @(negedge clk); #1; t++; end
    if (!EvictReady) check("enqueue_timeout", 0, 1);
    else pushBeats(adr, seed, way);
    @(posedge clk); #1;
    EvictValid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int t = 0;
    while ((expQ.size() != 0 || BusValid) && t < 500) begin @(negedge clk); #1; t++; end
    check({name, "_drained"}, 64'(expQ.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic waitBeat(input logic [5:0] off, input string name);
    int t = 0;
    @(negedge clk); #1;
    while (!(BusValid && BusReady && BusAdr[5:0] == off) && t < 200) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 200) check({name, "_beat_timeout"}, 0, 1);
  endtask

  always @(negedge clk) begin
    if (reset_n && BusValid && BusReady) begin
      beat_t e;
      beatsSeen++;
      if (expQ.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = expQ.pop_front();
        check("BusAdr", 64'(BusAdr), 64'(e.adr));
        check("BusData", BusData, e.data);
        check("BusLast", 64'(BusLast), 64'(e.last));
        check("BusWay", 64'(BusWay), 64'(e.way));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lkVec_t vecs[5];
    int     n0, n, stalls, t;
    logic [55:0] sAdr;
    logic [63:0] sData;
    logic        sLast, prevStall;
    logic [3:0]  pat;

    vecs[0] = '{56'h80001040, 56'h80001078, 1'b1};
    vecs[1] = '{56'h80001040, 56'h80001080, 1'b0};
    vecs[2] = '{56'h80001040, 56'h8000103F, 1'b0};
    vecs[3] = '{56'h00000012345000, 56'h80000012345000, 1'b0};
    vecs[4] = '{56'h7FFFFFC0, 56'h7FFFFFFF, 1'b1};

    reset_n = 1'b0; EvictValid = 1'b0; EvictAdr = '0; EvictLine = '0; EvictWay = '0;
    BusReady = 1'b0; LookupAdr = 56'h80001040;
    #12;
    check("rst_BusValid", 64'(BusValid), 0);
    check("rst_BusLast", 64'(BusLast), 0);
    check("rst_EvictReady", 64'(EvictReady), 1);
    check("rst_Empty", 64'(Empty), 1);
    check("rst_LookupHit", 64'(LookupHit), 0);
    @(posedge clk); #1; reset_n = 1'b1;
    @(posedge clk); #1;

    // single eviction
    BusReady = 1'b1;
    n0 = beatsSeen;
    enqueue(56'h80001040, 8'h00, 4'b0010);
    waitDrain("single");
    check("single_beats", 64'(beatsSeen - n0), 8);
    check("single_Empty", 64'(Empty), 1);

    // backpressure with 1,0,0,1 ready pattern
    pat = 4'b1001;
    BusReady = 1'b0;
    n0 = beatsSeen;
    enqueue(56'h80002000, 8'h40, 4'b0100);
    prevStall = 1'b0; stalls = 0; t = 0;
    while ((expQ.size() != 0 || BusValid) && t < 200) begin
      BusReady = pat[t % 4];
      @(negedge clk); #1;
      if (BusValid) begin
        if (prevStall) begin
          stalls++;
          check("stall_BusAdr", 64'(BusAdr), 64'(sAdr));
          check("stall_BusData", BusData, sData);
          check("stall_BusLast", 64'(BusLast), 64'(sLast));
        end
        prevStall = !BusReady;
        sAdr = BusAdr; sData = BusData; sLast = BusLast;
      end
      @(posedge clk); #1;
      t++;
    end
    check("bp_handshakes", 64'(beatsSeen - n0), 8);
    check("bp_stalls_seen", 64'(stalls > 0), 1);
    BusReady = 1'b1;
    waitDrain("bp");

    // full buffer
    BusReady = 1'b0;
    enqueue(56'h80003000, 8'h10, 4'b0001);
    enqueue(56'h80003040, 8'h20, 4'b0010);
    @(negedge clk); #1;
    check("full_EvictReady", 64'(EvictReady), 0);
    EvictValid = 1'b1; EvictAdr = 56'h80003080; EvictLine = mkLine(8'h30); EvictWay = 4'b1000;
    repeat (3) begin @(negedge clk); #1; check("full_held_off", 64'(EvictReady), 0); end
    @(posedge clk); #1;
    BusReady = 1'b1;
    t = 0;
    @(negedge clk); #1;
    while (!(BusValid && BusLast) && t < 50) begin @(negedge clk); #1; t++; end
    check("full_last_EvictReady", 64'(EvictReady), 0);
    @(negedge clk); #1;
    check("full_after_EvictReady", 64'(EvictReady), 1);
    check("full_no_bubble", 64'(BusValid), 1);
    pushBeats(56'h80003080, 8'h30, 4'b1000);
    @(posedge clk); #1;
    EvictValid = 1'b0;
    waitDrain("full");

    // lookup vector table
    for (int i = 0; i < 5; i++) begin
      BusReady = 1'b0;
      LookupAdr = vecs[i].lkAdr;
      enqueue(vecs[i].evAdr, 8'(i * 3), 4'b0001);
      @(negedge clk); #1;
      check($sformatf("lookup_vec%0d", i), 64'(LookupHit), 64'(vecs[i].expHit));
      @(posedge clk); #1;
      BusReady = 1'b1;
      waitDrain($sformatf("lookup_vec%0d", i));
      check($sformatf("lookup_vec%0d_clear", i), 64'(LookupHit), 0);
    end

    // lookup hit held through the last beat; not counted during the enqueue cycle
    BusReady = 1'b1;
    LookupAdr = 56'h80001078;
    EvictValid = 1'b1; EvictAdr = 56'h80001040; EvictLine = mkLine(8'h55); EvictWay = 4'b0100;
    @(negedge clk); #1;
    check("lookup_enq_cycle", 64'(LookupHit), 0);
    pushBeats(56'h80001040, 8'h55, 4'b0100);
    @(posedge clk); #1;
    EvictValid = 1'b0;
    t = 0;
    @(negedge clk); #1;
    while (!(BusValid && BusLast) && t < 50) begin
      check("lookup_resident", 64'(LookupHit), 1);
      @(negedge clk); #1; t++;
    end
    check("lookup_last_beat", 64'(LookupHit), 1);
    @(negedge clk); #1;
    check("lookup_after_last", 64'(LookupHit), 0);
    waitDrain("lookup_hold");

    // simultaneous enqueue and last-beat dequeue, wrapping pointers over 5 lines
    BusReady = 1'b1;
    enqueue(56'h90000000, 8'h00, 4'b0001);
    for (int k = 1; k < 5; k++) begin
      waitBeat(6'h30, "simul");
      @(posedge clk); #1;
      EvictValid = 1'b1; EvictAdr = 56'h90000000 + 56'(k * 64);
      EvictLine = mkLine(8'(k * 8'h11)); EvictWay = 4'(1 << (k % 4));
      @(negedge clk); #1;
      check("simul_last", 64'(BusLast), 1);
      check("simul_ready", 64'(EvictReady), 1);
      pushBeats(56'h90000000 + 56'(k * 64), 8'(k * 8'h11), 4'(1 << (k % 4)));
      @(posedge clk); #1;
      EvictValid = 1'b0;
      @(negedge clk); #1;
      check("simul_no_bubble", 64'(BusValid), 1);
      check("simul_count_one_nonempty", 64'(Empty), 0);
      check("simul_count_one_notfull", 64'(EvictReady), 1);
      check("simul_new_adr", 64'(BusAdr), 64'(56'h90000000 + 56'(k * 64)));
    end
    waitDrain("simul");

    // asynchronous reset mid-burst
    BusReady = 1'b1;
    enqueue(56'hA0000000, 8'h77, 4'b0010);
    waitBeat(6'h18, "reset");
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_BusValid", 64'(BusValid), 0);
    check("midrst_Empty", 64'(Empty), 1);
    check("midrst_EvictReady", 64'(EvictReady), 1);
    check("midrst_BusLast", 64'(BusLast), 0);
    expQ.delete();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    n0 = beatsSeen; n = 0;
    repeat (20) begin @(negedge clk); #1; if (BusValid) n++; end
    check("postrst_no_valid", 64'(n), 0);
    check("postrst_no_beats", 64'(beatsSeen - n0), 0);
    check("postrst_Empty", 64'(Empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_evict_buffer.md
Name: cache_evict_buffer

Overview:
- Write-back eviction buffer downstream of the cache victim-way selector.
- When the selected victim way holds a dirty line, the cache controller enqueues that line here. The buffer streams it to the bus interface as a fixed-length burst of beats.
- Lets the miss fill proceed without waiting for the write-back.
- Provides an address-match output so a fill from the same line cannot bypass a pending write-back.

Parameters:
- NUMWAYS, 4, cache associativity; width of the one-hot way tag.
- LINELEN, 512, cache line size in bits.
- BEATLEN, 64, bus beat width in bits; LINELEN must be a multiple of BEATLEN.
- PA_BITS, 56, physical address width.
- DEPTH, 2, number of line entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- EvictValid  input  1  controller presents a dirty victim line.
- EvictReady  output  1  buffer can accept a line this cycle.
- EvictAdr  input  PA_BITS  line address of the victim; offset bits are ignored.
- EvictLine  input  LINELEN  victim line data.
- EvictWay  input  NUMWAYS  one-hot victim way (from VictimWay); stored for debug/perf.
- BusValid  output  1  current beat is valid.
- BusReady  input  1  bus accepts the beat.
- BusAdr  output  PA_BITS  byte address of the current beat.
- BusData  output  BEATLEN  current beat data.
- BusLast  output  1  current beat is the final beat of the line.
- BusWay  output  NUMWAYS  EvictWay of the head entry.
- LookupAdr  input  PA_BITS  address of a pending miss.
- LookupHit  output  1  LookupAdr line matches a resident entry (combinational).
- Empty  output  1  no entries resident; used by fence/flush.

Behaviour:
- Derived values:
  - BEATS = LINELEN/BEATLEN.
  - OFFSETLEN = log2(LINELEN/8).
  - Line address = Adr[PA_BITS-1:OFFSETLEN].
- Storage: circular FIFO of DEPTH entries holding {line address, data, way, valid}. Pointers are log2(DEPTH) bits plus a wrap bit.
- Enqueue:
  - EvictReady = ~full, decoded from registered state only; there is no same-cycle bypass.
  - A full buffer holds EvictReady=0 even in the cycle the last beat drains; it rises the following cycle.
  - EvictValid&EvictReady writes the tail entry at the clock edge, and the entry becomes visible to the drain side the next cycle. Minimum latency from enqueue to first BusValid is 1 cycle.
- Drain FSM:
  - IDLE: BusValid=0. Go to BURST when not empty; beat counter=0.
  - BURST: BusValid=1.
    - BusData = head data slice [beat*BEATLEN +: BEATLEN].
    - BusAdr = {head line address, OFFSETLEN zeros} + beat*(BEATLEN/8).
    - BusLast = (beat==BEATS-1).
    - On BusValid&BusReady: beat increments.
    - On last-beat acceptance: head invalidated, head pointer advances, beat=0. Stay in BURST if another entry remains (back-to-back bursts, no bubble); otherwise go to IDLE.
- Output stability: BusAdr, BusData, BusLast and BusWay are held constant while BusValid=1 and BusReady=0.
- Beat counter: log2(BEATS) bits. Wrap from BEATS-1 to 0 occurs only with the head advance.
- LookupHit:
  - OR over valid entries of (entry line address == LookupAdr line address).
  - The entry being drained counts until the clock edge that accepts its last beat.
  - An entry being enqueued this cycle does not count.
- Simultaneous enqueue and last-beat dequeue (not full): both take effect; count is unchanged.
- Duplicate line address enqueued: accepted and drained in FIFO order; no merging.
- Empty = (count==0), from registered state.
- Reset: asynchronous assertion of reset_n=0.
  - Clears pointers, valid bits, beat counter and FSM to IDLE.
  - Outputs: BusValid=0, BusLast=0, EvictReady=1, Empty=1, LookupHit=0.
  - Reset mid-burst discards all entries; the data-array contents are don't-care.

Decomposition:
- Package cache_evict_pkg holds:
  - drain state enum {IDLE, BURST};
  - a beat-index function;
  - constants BEATS and OFFSETLEN derived from parameters.
- One sub-module, cache_evict_entry_cam: per-entry line-address registers plus the parallel compare producing LookupHit. It takes DEPTH and the tag width as parameters.
- The FIFO control and drain FSM stay in the top module.

Test Plan:
- Single eviction:
  - Stimulus: enqueue line at EvictAdr=0x80001040, data bytes 0x00..0x3F, BusReady=1.
  - Expected: 8 beats at BusAdr 0x80001040..0x80001078, step 8.
  - Beat0 data = 0x0706050403020100; BusLast only on beat 7; Empty=1 after.
- Backpressure:
  - Stimulus: BusReady toggles 1,0,0,1 during the burst.
  - Expected: BusAdr, BusData and BusLast unchanged across stall cycles; exactly 8 handshakes.
- Full:
  - Stimulus: enqueue 2 lines with BusReady=0.
  - Expected: EvictReady=0; a third EvictValid is held off.
  - After the last beat of entry 0 is accepted, EvictReady=1 one cycle later.
  - The second burst starts with no idle cycle.
- LookupHit:
  - Stimulus: entry 0x80001040 resident, LookupAdr=0x80001078.
  - Expected: LookupHit=1 through the last-beat cycle, 0 the next cycle. LookupAdr=0x80001080 gives 0.
- Simultaneous:
  - Stimulus: one entry on its last beat while a new enqueue occurs.
  - Expected: count stays 1, the next burst uses the new address, pointer wrap is exercised over 5 lines.
- Reset mid-burst:
  - Stimulus: assert reset_n=0 asynchronously at beat 3.
  - Expected: BusValid=0 immediately, Empty=1, EvictReady=1; no further beats after release.
